// File: rtl/sensor_bcd_formatter_if.sv
// Sample handshake between the sensor bus reader and the BCD formatter.
interface sensor_bcd_formatter_if;
  logic        raw_valid;
  logic        raw_ready;
  logic [15:0] raw_rh;
  logic [15:0] raw_temp;

  // Upstream reader drives the sample words and valid.
  modport master (
    output raw_valid,
    output raw_rh,
    output raw_temp,
    input  raw_ready
  );

  // Formatter accepts the sample and reports readiness.
  modport slave (
    input  raw_valid,
    input  raw_rh,
    input  raw_temp,
    output raw_ready
  );
endinterface

// File: rtl/sensor_bcd_formatter.sv
// Converts raw HDC1080-style RH/temperature words into packed BCD display words.
// A sample is scaled once, then each value is converted serially with double-dabble.
// Both display words are written on a single edge so the display never shows a mix
// of two samples.
module sensor_bcd_formatter #(
  parameter int unsigned CONV_BITS = 10,
  parameter int unsigned RH_SCALE  = 1000,
  parameter int unsigned T_SPAN    = 165,
  parameter int unsigned T_OFFSET  = 40
) (
  input  logic                         CLK100MHZ,
  input  logic                         CPU_RESETN,
  sensor_bcd_formatter_if.slave        raw,
  output logic [15:0]                  RH_Value,
  output logic [15:0]                  Temp_Value,
  output logic                         update_pulse,
  output logic                         overrun
);

  localparam int unsigned CntW = $clog2(CONV_BITS + 1);

  typedef enum logic [1:0] {StIdle, StScale, StConvRh, StConvT} state_e;

  state_e                 state_q;
  logic                   ready_q;
  logic [15:0]            raw_rh_q;
  logic [15:0]            raw_temp_q;
  logic [CONV_BITS-1:0]   rh10_q;
  logic [CONV_BITS-1:0]   mag_q;
  logic                   neg_q;
  logic [CONV_BITS-1:0]   bin_q;
  logic [11:0]            bcd_q;
  logic [11:0]            rh_bcd_q;
  logic [CntW-1:0]        cnt_q;

  logic [31:0]            rh_prod;
  logic [31:0]            t_prod;
  logic [15:0]            tq;
  logic [CONV_BITS-1:0]   rh10_c;
  logic [CONV_BITS-1:0]   mag_c;
  logic                   neg_c;
  logic [11:0]            bcd_step;
  logic [CONV_BITS-1:0]   bin_step;

  assign raw.raw_ready = ready_q;

  // Fixed-point scaling of the captured sample; products are full 32-bit, results truncate.
  always_comb begin
    rh_prod = 32'(raw_rh_q) * RH_SCALE;
    t_prod  = 32'(raw_temp_q) * T_SPAN;
    tq      = 16'(t_prod >> 16);
    rh10_c  = CONV_BITS'(rh_prod >> 16);
    neg_c   = (tq < 16'(T_OFFSET));
    if (neg_c) begin
      mag_c = CONV_BITS'(16'(T_OFFSET) - tq);
    end else begin
      mag_c = CONV_BITS'(tq - 16'(T_OFFSET));
    end
  end

  // One double-dabble iteration: add 3 to digits >= 5, then shift in the next binary bit.
  always_comb begin
    logic [11:0] adj;
    adj = bcd_q;
    for (int d = 0; d < 3; d++) begin
      if (adj[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
      end
    end
    bcd_step = 12'({adj, bin_q[CONV_BITS-1]});
    bin_step = bin_q << 1;
  end

  // Control FSM with registered outputs; display words change only on the final CONV_T edge.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q      <= StIdle;
      ready_q      <= 1'b1;
      raw_rh_q     <= '0;
      raw_temp_q   <= '0;
      rh10_q       <= '0;
      mag_q        <= '0;
      neg_q        <= 1'b0;
      bin_q        <= '0;
      bcd_q        <= '0;
      rh_bcd_q     <= '0;
      cnt_q        <= '0;
      RH_Value     <= '0;
      Temp_Value   <= '0;
      update_pulse <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      update_pulse <= 1'b0;
      // A sample offered while busy is lost; remember that until reset.
      if (raw.raw_valid && !ready_q) begin
        overrun <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (raw.raw_valid && ready_q) begin
            raw_rh_q   <= raw.raw_rh;
            raw_temp_q <= raw.raw_temp;
            ready_q    <= 1'b0;
            state_q    <= StScale;
          end
        end
        StScale: begin
          rh10_q  <= rh10_c;
          mag_q   <= mag_c;
          neg_q   <= neg_c;
          cnt_q   <= '0;
          state_q <= StConvRh;
        end
        StConvRh: begin
          if (cnt_q == '0) begin
            bin_q <= rh10_q;
            bcd_q <= '0;
            cnt_q <= CntW'(1);
          end else begin
            bin_q <= bin_step;
            bcd_q <= bcd_step;
            if (cnt_q == CntW'(CONV_BITS)) begin
              rh_bcd_q <= bcd_step;
              cnt_q    <= '0;
              state_q  <= StConvT;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StConvT: begin
          if (cnt_q == '0) begin
            bin_q <= mag_q;
            bcd_q <= '0;
            cnt_q <= CntW'(1);
          end else begin
            bin_q <= bin_step;
            bcd_q <= bcd_step;
            if (cnt_q == CntW'(CONV_BITS)) begin
              // Final iteration result goes straight to the display with the RH word.
              RH_Value     <= {4'h0, rh_bcd_q};
              Temp_Value   <= {(neg_q ? 4'hF : 4'h0), bcd_step};
              update_pulse <= 1'b1;
              ready_q      <= 1'b1;
              cnt_q        <= '0;
              state_q      <= StIdle;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_bcd_formatter.sv
// Self-checking bench for sensor_bcd_formatter: directed vectors, randomized samples
// against an arithmetic reference model, and multi-cycle handshake corner cases.
module tb_sensor_bcd_formatter;

  logic        CLK100MHZ = 1'b0;
  logic        CPU_RESETN = 1'b1;
  logic [15:0] RH_Value;
  logic [15:0] Temp_Value;
  logic        update_pulse;
  logic        overrun;

  int checks = 0;
  int failures = 0;
  logic [15:0] cur_rh = 16'h0000;
  logic [15:0] cur_t  = 16'h0000;

  sensor_bcd_formatter_if bus ();

  sensor_bcd_formatter dut (
    .CLK100MHZ    (CLK100MHZ),
    .CPU_RESETN   (CPU_RESETN),
    .raw          (bus),
    .RH_Value     (RH_Value),
    .Temp_Value   (Temp_Value),
    .update_pulse (update_pulse),
    .overrun      (overrun)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct {
    logic [15:0] rh;
    logic [15:0] temp;
    logic [15:0] exp_rh;
    logic [15:0] exp_t;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: scale with plain integer arithmetic, then split into decimal digits.
  function automatic logic [31:0] model(input logic [15:0] rh, input logic [15:0] t);
    int unsigned r;
    int unsigned tq;
    int unsigned m;
    logic        neg;
    logic [15:0] rb;
    logic [15:0] tb;
    r   = (int'(rh) * 1000) / 65536;
    tq  = (int'(t) * 165) / 65536;
    neg = (tq < 40);
    m   = neg ? (40 - tq) : (tq - 40);
    rb  = {4'h0, 4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
    tb  = {(neg ? 4'hF : 4'h0), 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    return {rb, tb};
  endfunction

  // Offer one sample (caller sits #1 after an edge), wait for the update, check it.
  // inject_at >= 0 drives a second valid during the cycle after that many edges.
  task automatic convert(input logic [15:0] rh, input logic [15:0] t,
                         input logic [15:0] exp_rh, input logic [15:0] exp_t,
                         input string name, input int inject_at);
    int lat;
    bit seen;
    chk({name, " ready_before"}, 32'(bus.raw_ready), 32'd1);
    bus.raw_rh    = rh;
    bus.raw_temp  = t;
    bus.raw_valid = 1'b1;
    @(posedge CLK100MHZ);
    #1;
    bus.raw_valid = 1'b0;
    chk({name, " ready_busy"}, 32'(bus.raw_ready), 32'd0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (lat == inject_at) begin
        bus.raw_valid = 1'b1;
        bus.raw_rh    = 16'($urandom);
        bus.raw_temp  = 16'($urandom);
      end
      @(posedge CLK100MHZ);
      #1;
      bus.raw_valid = 1'b0;
      lat++;
      if (update_pulse) begin
        seen = 1'b1;
      end else begin
        chk({name, " hold"}, {RH_Value, Temp_Value}, {cur_rh, cur_t});
      end
    end
    chk({name, " latency"}, 32'(lat), 32'd23);
    chk({name, " rh"}, 32'(RH_Value), 32'(exp_rh));
    chk({name, " temp"}, 32'(Temp_Value), 32'(exp_t));
    chk({name, " ready_after"}, 32'(bus.raw_ready), 32'd1);
    cur_rh = exp_rh;
    cur_t  = exp_t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m;
    logic [15:0] rh;
    logic [15:0] t;
    logic [31:0] expq[$];
    int last_cap;
    int caps;
    int pulses;

    vecs[0] = '{16'h8000, 16'h8000, 16'h0500, 16'h0042};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h0999, 16'h0124};
    vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 16'hF040};
    vecs[3] = '{16'h1234, 16'h3E0F, 16'h0071, 16'hF001};
    vecs[4] = '{16'h4000, 16'h3E10, 16'h0250, 16'h0000};

    bus.raw_valid = 1'b0;
    bus.raw_rh    = 16'h0;
    bus.raw_temp  = 16'h0;

    // Reset state
    #2 CPU_RESETN = 1'b0;
    repeat (3) @(posedge CLK100MHZ);
    #1;
    chk("reset rh", 32'(RH_Value), 32'h0);
    chk("reset temp", 32'(Temp_Value), 32'h0);
    chk("reset ready", 32'(bus.raw_ready), 32'd1);
    chk("reset pulse", 32'(update_pulse), 32'd0);
    chk("reset overrun", 32'(overrun), 32'd0);
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    @(posedge CLK100MHZ);
    #1;

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      convert(vecs[i].rh, vecs[i].temp, vecs[i].exp_rh, vecs[i].exp_t,
              $sformatf("vec%0d", i), -1);
      @(posedge CLK100MHZ);
      #1;
      chk($sformatf("vec%0d pulse_width", i), 32'(update_pulse), 32'd0);
    end

    // Randomized samples against the model
    for (int i = 0; i < 8; i++) begin
      rh = 16'($urandom);
      t  = 16'($urandom);
      m  = model(rh, t);
      convert(rh, t, m[31:16], m[15:0], $sformatf("rand%0d", i), -1);
      repeat ($urandom_range(0, 3)) begin
        @(posedge CLK100MHZ);
        #1;
      end
    end
    chk("no overrun yet", 32'(overrun), 32'd0);

    // Drop while busy, then back-to-back capture on E24
    m = model(16'hA5A5, 16'h6000);
    convert(16'hA5A5, 16'h6000, m[31:16], m[15:0], "overrun_first", 5);
    chk("overrun set", 32'(overrun), 32'd1);
    m = model(16'h2222, 16'hC000);
    convert(16'h2222, 16'hC000, m[31:16], m[15:0], "b2b_e24", -1);
    chk("overrun sticky", 32'(overrun), 32'd1);

    // Reset in the middle of a conversion
    bus.raw_rh    = 16'h7777;
    bus.raw_temp  = 16'h9999;
    bus.raw_valid = 1'b1;
    @(posedge CLK100MHZ);
    #1;
    bus.raw_valid = 1'b0;
    repeat (9) @(posedge CLK100MHZ);
    #1;
    CPU_RESETN = 1'b0;
    #1;
    chk("midreset rh", 32'(RH_Value), 32'h0);
    chk("midreset temp", 32'(Temp_Value), 32'h0);
    chk("midreset ready", 32'(bus.raw_ready), 32'd1);
    chk("midreset overrun", 32'(overrun), 32'd0);
    cur_rh = 16'h0;
    cur_t  = 16'h0;
    pulses = 0;
    repeat (2) @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge CLK100MHZ);
      #1;
      if (update_pulse) pulses++;
    end
    chk("midreset no pulse", 32'(pulses), 32'd0);
    m = model(16'h8000, 16'h8000);
    convert(16'h8000, 16'h8000, m[31:16], m[15:0], "after_reset", -1);
    chk("after_reset overrun", 32'(overrun), 32'd0);

    // Valid on the completion edge is dropped, not captured
    @(posedge CLK100MHZ);
    #1;
    m = model(16'h0F0F, 16'h3000);
    convert(16'h0F0F, 16'h3000, m[31:16], m[15:0], "e23_valid", 22);
    chk("e23 overrun", 32'(overrun), 32'd1);
    @(posedge CLK100MHZ);
    #1;
    chk("e23 not captured", 32'(bus.raw_ready), 32'd1);
    chk("e23 pulse_width", 32'(update_pulse), 32'd0);

    // Continuous valid with changing data
    last_cap = -1;
    caps     = 0;
    pulses   = 0;
    for (int c = 0; c < 220; c++) begin
      if (c < 192) begin
        rh = 16'($urandom);
        t  = 16'($urandom);
        bus.raw_rh    = rh;
        bus.raw_temp  = t;
        bus.raw_valid = 1'b1;
        if (bus.raw_ready) begin
          expq.push_back(model(rh, t));
          if (last_cap >= 0) chk("stream spacing", 32'(c - last_cap), 32'd24);
          last_cap = c;
          caps++;
        end
      end else begin
        bus.raw_valid = 1'b0;
      end
      @(posedge CLK100MHZ);
      #1;
      if (update_pulse) begin
        pulses++;
        if (expq.size() == 0) begin
          chk("stream unexpected pulse", 32'(pulses), 32'(caps));
        end else begin
          m = expq.pop_front();
          chk("stream outputs", {RH_Value, Temp_Value}, m);
          cur_rh = m[31:16];
          cur_t  = m[15:0];
        end
      end else begin
        chk("stream hold", {RH_Value, Temp_Value}, {cur_rh, cur_t});
      end
    end
    bus.raw_valid = 1'b0;
    chk("stream captures", 32'(caps), 32'd8);
    chk("stream pulses", 32'(pulses), 32'(caps));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
